ccip_host_mem_responder: RTL

// - Host-memory-side responder for CCI-P-style single-line traffic; AFU unit benches use it as the
//   far end of the AFU's c0 read / c1 write request channels.
// - Backs a window of 2**ADDR_BITS 512-bit lines with internal RAM.
// - Returns read data and write acks after a fixed pipeline latency.
// - Models host congestion through almost-full outputs and a bench-driven response hold.

---
 rtl/ccip_host_mem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ccip_host_mem_responder.sv
// Host-memory far end for CCI-P-style c0 read / c1 write channels: RAM-backed window,
// fixed-latency responses, per-channel response FIFOs with almost-full and bench-driven hold.
module ccip_host_mem_responder #(
    parameter int unsigned ADDR_BITS       = 10,
    parameter int unsigned LATENCY         = 8,
    parameter int unsigned QUEUE_DEPTH     = 64,
    parameter int unsigned ALM_FULL_THRESH = 56
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [41:0]  base_addr,
    input  logic         c0_req_valid,
    input  logic [41:0]  c0_req_addr,
    input  logic [15:0]  c0_req_mdata,
    input  logic         c1_req_valid,
    input  logic [41:0]  c1_req_addr,
    input  logic [15:0]  c1_req_mdata,
    input  logic [511:0] c1_req_data,
    input  logic         rsp_hold,
    output logic         c0_rsp_valid,
    output logic [15:0]  c0_rsp_mdata,
    output logic [511:0] c0_rsp_data,
    output logic         c1_rsp_valid,
    output logic [15:0]  c1_rsp_mdata,
    output logic         c0_alm_full,
    output logic         c1_alm_full,
    output logic [1:0]   ovf_sticky,
    output logic [31:0]  oor_cnt,
    output logic [31:0]  rd_cnt,
    output logic [31:0]  wr_cnt
);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DL = LATENCY - 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(ALM_FULL_THRESH);

    logic [511:0] r_mem [0:(1<<ADDR_BITS)-1];

    logic [41:0]          w_c0_idx, w_c1_idx;
    logic                 w_c0_inr, w_c1_inr;
    logic                 w_c0_acc, w_c1_acc;
    logic                 w_c0_pop, w_c1_pop;
    logic                 w_c0_push, w_c1_push;
    logic [CW-1:0]        w_c0_out_nxt, w_c1_out_nxt;

    logic [DL-1:0]        r_c0_dv, r_c1_dv;
    logic [15:0]          r_c0_dm [DL];
    logic [15:0]          r_c1_dm [DL];
    logic [511:0]         r_c0_dd [DL];

    logic [15:0]          r_c0_fm [QUEUE_DEPTH];
    logic [511:0]         r_c0_fd [QUEUE_DEPTH];
    logic [15:0]          r_c1_fm [QUEUE_DEPTH];
    logic [CW-1:0]        r_c0_wp, r_c0_rp, r_c1_wp, r_c1_rp;
    logic [CW-1:0]        r_c0_out, r_c1_out;
    logic                 r_c0_alm, r_c1_alm;
    logic [1:0]           r_ovf;
    logic [31:0]          r_oor, r_rd, r_wr;

    always_comb begin
        w_c0_idx     = c0_req_addr - base_addr;
        w_c1_idx     = c1_req_addr - base_addr;
        w_c0_inr     = (w_c0_idx >> ADDR_BITS) == '0;
        w_c1_inr     = (w_c1_idx >> ADDR_BITS) == '0;
        w_c0_acc     = !reset && c0_req_valid && (r_c0_out < DEPTH_C);
        w_c1_acc     = !reset && c1_req_valid && (r_c1_out < DEPTH_C);
        w_c0_push    = r_c0_dv[DL-1];
        w_c1_push    = r_c1_dv[DL-1];
        w_c0_pop     = !reset && !rsp_hold && (r_c0_wp != r_c0_rp);
        w_c1_pop     = !reset && !rsp_hold && (r_c1_wp != r_c1_rp);
        w_c0_out_nxt = r_c0_out + CW'(w_c0_acc) - CW'(w_c0_pop);
        w_c1_out_nxt = r_c1_out + CW'(w_c1_acc) - CW'(w_c1_pop);
    end

    // RAM is deliberately not reset; the read snapshot below samples it before this write lands.
    always_ff @(posedge clk) begin
        if (w_c1_acc && w_c1_inr)
            r_mem[w_c1_idx[ADDR_BITS-1:0]] <= c1_req_data;
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 1; i < DL; i++) begin
            r_c0_dm[i] <= r_c0_dm[i-1];
            r_c0_dd[i] <= r_c0_dd[i-1];
            r_c1_dm[i] <= r_c1_dm[i-1];
        end
        r_c0_dm[0] <= c0_req_mdata;
        r_c0_dd[0] <= w_c0_inr ? r_mem[w_c0_idx[ADDR_BITS-1:0]] : '0;
        r_c1_dm[0] <= c1_req_mdata;
        if (w_c0_push) begin
            r_c0_fm[r_c0_wp[PW-1:0]] <= r_c0_dm[DL-1];
            r_c0_fd[r_c0_wp[PW-1:0]] <= r_c0_dd[DL-1];
        end
        if (w_c1_push)
            r_c1_fm[r_c1_wp[PW-1:0]] <= r_c1_dm[DL-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c0_dv  <= '0;
            r_c1_dv  <= '0;
            r_c0_wp  <= '0;
            r_c0_rp  <= '0;
            r_c1_wp  <= '0;
            r_c1_rp  <= '0;
            r_c0_out <= '0;
            r_c1_out <= '0;
            r_c0_alm <= 1'b0;
            r_c1_alm <= 1'b0;
            r_ovf    <= '0;
            r_oor    <= '0;
            r_rd     <= '0;
            r_wr     <= '0;
        end else begin
            for (int unsigned i = 1; i < DL; i++) begin
                r_c0_dv[i] <= r_c0_dv[i-1];
                r_c1_dv[i] <= r_c1_dv[i-1];
            end
            r_c0_dv[0] <= w_c0_acc;
            r_c1_dv[0] <= w_c1_acc;
            r_c0_wp    <= r_c0_wp + CW'(w_c0_push);
            r_c1_wp    <= r_c1_wp + CW'(w_c1_push);
            r_c0_rp    <= r_c0_rp + CW'(w_c0_pop);
            r_c1_rp    <= r_c1_rp + CW'(w_c1_pop);
            r_c0_out   <= w_c0_out_nxt;
            r_c1_out   <= w_c1_out_nxt;
            r_c0_alm   <= w_c0_out_nxt >= THRESH_C;
            r_c1_alm   <= w_c1_out_nxt >= THRESH_C;
            r_ovf[0]   <= r_ovf[0] | (c0_req_valid && !w_c0_acc);
            r_ovf[1]   <= r_ovf[1] | (c1_req_valid && !w_c1_acc);
            r_oor      <= r_oor + 32'(w_c0_acc && !w_c0_inr) + 32'(w_c1_acc && !w_c1_inr);
            r_rd       <= r_rd + 32'(w_c0_pop);
            r_wr       <= r_wr + 32'(w_c1_pop);
        end
    end

    always_comb begin
        c0_rsp_valid = w_c0_pop;
        c0_rsp_mdata = w_c0_pop ? r_c0_fm[r_c0_rp[PW-1:0]] : '0;
        c0_rsp_data  = w_c0_pop ? r_c0_fd[r_c0_rp[PW-1:0]] : '0;
        c1_rsp_valid = w_c1_pop;
        c1_rsp_mdata = w_c1_pop ? r_c1_fm[r_c1_rp[PW-1:0]] : '0;
        c0_alm_full  = r_c0_alm;
        c1_alm_full  = r_c1_alm;
        ovf_sticky   = r_ovf;
        oor_cnt      = r_oor;
        rd_cnt       = r_rd;
        wr_cnt       = r_wr;
    end
endmodule
